// File: rtl/conv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : conv_pkg                                                      |
// | Shared defaults, FSM state encoding and fixed-point saturation for the |
// | streaming convolution engine.                                          |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
package conv_pkg;

  localparam int c_def_bitwidth = 16;
  localparam int c_def_frac     = 10;
  localparam int c_def_img_w    = 32;
  localparam int c_def_img_h    = 32;
  localparam int c_def_k        = 5;
  localparam int c_def_ch       = 2;

  typedef logic [0:0] conv_state_t;
  localparam conv_state_t c_st_idle   = 1'b0;
  localparam conv_state_t c_st_active = 1'b1;

  // Clamp a sign-extended value into the signed range of a width-bit word.
  function automatic logic signed [63:0] conv_sat(input logic signed [63:0] value,
                                                  input int unsigned width);
    logic signed [63:0] w_hi;
    logic signed [63:0] w_lo;
    w_hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    w_lo = -(64'sd1 <<< (width - 1));
    if (value > w_hi)
      conv_sat = w_hi;
    else if (value < w_lo)
      conv_sat = w_lo;
    else
      conv_sat = value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_stream_engine_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : conv_stream_engine_if                                         |
// | Weight-write port, pixel input stream and result output stream.        |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
interface conv_stream_engine_if
  import conv_pkg::*;
#(
  parameter int BITWIDTH = c_def_bitwidth,
  parameter int K        = c_def_k,
  parameter int CH       = c_def_ch
);

  localparam int c_chw  = (CH > 1) ? $clog2(CH) : 1;
  localparam int c_idxw = (K * K > 1) ? $clog2(K * K) : 1;

  logic                   k_wr_en;
  logic [c_chw-1:0]       k_wr_ch;
  logic [c_idxw-1:0]      k_wr_idx;
  logic [BITWIDTH-1:0]    k_wr_data;

  logic                   in_valid;
  logic                   in_ready;
  logic [BITWIDTH-1:0]    in_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [CH*BITWIDTH-1:0] out_data;
  logic                   out_last;
  logic                   busy;

  modport master (
    output k_wr_en, k_wr_ch, k_wr_idx, k_wr_data,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  k_wr_en, k_wr_ch, k_wr_idx, k_wr_data,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/conv_window_mac.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : conv_window_mac                                               |
// | Combinational KxK window dot product, shifted and saturated; negative  |
// | results clamp to zero when CONV_RELU_EN is defined.                    |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int BITWIDTH = c_def_bitwidth,
  parameter int FRAC     = c_def_frac,
  parameter int K        = c_def_k
) (
  input  logic [K*K*BITWIDTH-1:0] win,
  input  logic [K*K*BITWIDTH-1:0] wts,
  output logic [BITWIDTH-1:0]     result
);

  localparam int c_taps = K * K;
  localparam int c_accw = 2 * BITWIDTH + $clog2(c_taps);

  logic signed [2*BITWIDTH-1:0] w_prod [c_taps];
  logic signed [c_accw-1:0]     w_acc;
  logic signed [c_accw-1:0]     w_shift;
  logic signed [BITWIDTH-1:0]   w_sat;

  for (genvar gi = 0; gi < c_taps; gi++) begin : g_tap
    assign w_prod[gi] = $signed(win[gi*BITWIDTH +: BITWIDTH]) *
                        $signed(wts[gi*BITWIDTH +: BITWIDTH]);
  end

  always_comb begin
    w_acc = '0;
    for (int t = 0; t < c_taps; t++)
      w_acc = w_acc + c_accw'(w_prod[t]);
  end

  assign w_shift = w_acc >>> FRAC;
  assign w_sat   = BITWIDTH'(conv_sat(64'(w_shift), BITWIDTH));

`ifdef CONV_RELU_EN
  assign result = w_sat[BITWIDTH-1] ? '0 : w_sat;
`else
  assign result = w_sat;
`endif

endmodule
`default_nettype wire

// File: rtl/conv_stream_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : conv_stream_engine                                            |
// | Raster-stream KxK convolution over CH parallel output channels, with   |
// | line buffers, a sliding window and a registered output stage.          |
// | Optional: CONV_RELU_EN (handled in conv_window_mac).                   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int BITWIDTH = c_def_bitwidth,
  parameter int FRAC     = c_def_frac,
  parameter int IMG_W    = c_def_img_w,
  parameter int IMG_H    = c_def_img_h,
  parameter int K        = c_def_k,
  parameter int CH       = c_def_ch
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_stream_engine_if.slave bus
);

  localparam int c_colw = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_roww = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_taps = K * K;

  logic [c_colw-1:0]      r_col;
  logic [c_roww-1:0]      r_row;
  conv_state_t            r_state;
  conv_state_t            w_state_next;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic [CH*BITWIDTH-1:0] r_out_data;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_col_end;
  logic                   w_row_end;
  logic                   w_emit;
  logic                   w_busy;
  logic                   w_wr_ok;
  logic [CH*BITWIDTH-1:0] w_res;

  logic [BITWIDTH-1:0]    r_lb  [K-1][IMG_W];
  logic [BITWIDTH-1:0]    r_win [K][K];
  logic [BITWIDTH-1:0]    w_win_next [K][K];
  logic [BITWIDTH-1:0]    w_colv [K];
  logic [c_taps*BITWIDTH-1:0] w_win_flat;
  logic [BITWIDTH-1:0]    r_wt  [CH][c_taps];

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_col_end  = (r_col == c_colw'(IMG_W - 1));
  assign w_row_end  = (r_row == c_roww'(IMG_H - 1));
  assign w_emit     = w_accept && (r_row >= c_roww'(K - 1)) && (r_col >= c_colw'(K - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + c_roww'(1);
      end else begin
        r_col <= r_col + c_colw'(1);
      end
    end
  end

  // Column vector at the current x: K-1 buffered rows (oldest first) plus the live pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++)
      w_colv[r] = r_lb[r][r_col];
    w_colv[K-1] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < K - 1; r++)
        r_lb[r][r_col] <= w_colv[r+1];
    end
  end

  // The MAC sees the window including the pixel being accepted, so the result registers with it.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++)
        w_win_next[r][c] = r_win[r][c+1];
      w_win_next[r][K-1] = w_colv[r];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          r_win[r][c] <= w_win_next[r][c];
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w_win_flat[(r*K+c)*BITWIDTH +: BITWIDTH] = w_win_next[r][c];
  end

  assign w_wr_ok = bus.k_wr_en && !w_busy &&
                   (int'(bus.k_wr_ch) < CH) && (int'(bus.k_wr_idx) < c_taps);

  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_wt[bus.k_wr_ch][bus.k_wr_idx] <= bus.k_wr_data;
  end

  for (genvar gc = 0; gc < CH; gc++) begin : g_ch
    logic [c_taps*BITWIDTH-1:0] w_wt_flat;

    always_comb begin
      w_wt_flat = '0;
      for (int t = 0; t < c_taps; t++)
        w_wt_flat[t*BITWIDTH +: BITWIDTH] = r_wt[gc][t];
    end

    conv_window_mac #(
      .BITWIDTH (BITWIDTH),
      .FRAC     (FRAC),
      .K        (K)
    ) u_mac (
      .win    (w_win_flat),
      .wts    (w_wt_flat),
      .result (w_res[gc*BITWIDTH +: BITWIDTH])
    );
  end

  // A new result can only land when the previous one is gone or leaving this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_col_end && w_row_end;
      r_out_data  <= w_res;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= c_st_idle;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept)
          w_state_next = c_st_active;
      end
      c_st_active: begin
        if (r_out_valid && bus.out_ready && r_out_last && !w_accept)
          w_state_next = c_st_idle;
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == c_st_active);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_stream_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_conv_stream_engine                                         |
// | Self-checking bench for conv_stream_engine; honours CONV_RELU_EN.      |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_conv_stream_engine;

  localparam int BW   = 16;
  localparam int FR   = 10;
  localparam int W    = 32;
  localparam int H    = 32;
  localparam int K    = 5;
  localparam int CH   = 2;
  localparam int N    = W * H;
  localparam int NOUT = (W - K + 1) * (H - K + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_stream_engine_if #(.BITWIDTH(BW), .K(K), .CH(CH)) bus ();

  conv_stream_engine #(
    .BITWIDTH (BW),
    .FRAC     (FR),
    .IMG_W    (W),
    .IMG_H    (H),
    .K        (K),
    .CH       (CH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] pix;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req)
      n_pass++;
    else
      $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [15:0] post(input logic [15:0] v);
`ifdef CONV_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [15:0] pixval(input int mode, input logic [15:0] upix, input int idx);
    int r;
    int c;
    r = idx / W;
    c = idx % W;
    return (mode == 0) ? upix : 16'(r * 32 + c);
  endfunction

  task automatic wr(input int ch, input int idx, input logic [15:0] d);
    @(negedge clk);
    bus.k_wr_en   = 1'b1;
    bus.k_wr_ch   = 1'(ch);
    bus.k_wr_idx  = 5'(idx);
    bus.k_wr_data = d;
  endtask

  task automatic wr_end();
    @(negedge clk);
    bus.k_wr_en = 1'b0;
  endtask

  task automatic load_w(input logic [15:0] w0, input logic [15:0] w1, input bit ident);
    for (int t = 0; t < K * K; t++) begin
      wr(0, t, ident ? ((t == 12) ? w0 : 16'h0000) : w0);
      wr(1, t, ident ? ((t == 12) ? w1 : 16'h0000) : w1);
    end
    wr_end();
  endtask

  // mode 0: uniform pixel upix, expecting e0/e1; mode 1: ramp with identity kernels (ch1 doubled).
  // bp 0: always ready, 1: random out_ready, 2: 10-cycle stall near pixel 400.
  task automatic run_frame(input int mode, input logic [15:0] upix,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input int nframes, input int bp, input int stop_after,
                           input bit wr_busy);
    int   pix;
    int   outs;
    int   cyc;
    int   total;
    int   stall_left;
    bit   stall_done;
    bit   held_ok;
    bit   busy_chk;
    logic [31:0] held;
    exp_t e;
    pix = 0; outs = 0; cyc = 0; stall_left = 0;
    stall_done = 0; held_ok = 0; busy_chk = 0; held = '0;
    total = (stop_after > 0) ? stop_after : N * nframes;
    while (pix < total || (stop_after == 0 && sb.size() != 0)) begin
      @(negedge clk);
      if (bp == 2 && !stall_done && pix >= 400) begin
        stall_left = 10;
        stall_done = 1;
      end
      if (stall_left > 0)
        bus.out_ready = 1'b0;
      else if (bp == 1)
        bus.out_ready = ($urandom_range(0, 3) != 0);
      else
        bus.out_ready = 1'b1;
      bus.in_valid = (pix < total);
      bus.in_data  = pixval(mode, upix, pix % N);
      if (wr_busy && pix == 50) begin
        bus.k_wr_en   = 1'b1;
        bus.k_wr_ch   = 1'b0;
        bus.k_wr_idx  = 5'd12;
        bus.k_wr_data = 16'h0000;
      end else begin
        bus.k_wr_en = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        if (bus.out_valid) begin
          if (held_ok) begin
            check("stall in_ready", 32'(bus.in_ready), 32'd0);
            check("stall data hold", bus.out_data, held);
          end else begin
            held    = bus.out_data;
            held_ok = 1;
          end
        end
        stall_left--;
      end
      if (!busy_chk && pix == 200) begin
        check("busy mid-frame", 32'(bus.busy), 32'd1);
        busy_chk = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        outs++;
        if (sb.size() == 0) begin
          check("unexpected output", 32'(outs), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out data", bus.out_data, {e.d1, e.d0});
          check("out last", 32'(bus.out_last), 32'(e.last));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        int idx;
        int r;
        int c;
        idx = pix % N;
        r = idx / W;
        c = idx % W;
        if (r >= K - 1 && c >= K - 1) begin
          if (mode == 0) begin
            e.d0 = post(e0);
            e.d1 = post(e1);
          end else begin
            e.d0 = 16'((r - 2) * 32 + (c - 2));
            e.d1 = 16'(2 * ((r - 2) * 32 + (c - 2)));
          end
          e.last = (r == H - 1) && (c == W - 1);
          sb.push_back(e);
        end
        pix++;
      end
      cyc++;
      if (cyc > 4 * total + 200) begin
        check("frame timeout", 32'(cyc), 32'd0);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.k_wr_en   = 1'b0;
    if (stop_after == 0) begin
      check("output count", 32'(outs), 32'(NOUT * nframes));
      #1;
      check("busy after frame", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    bus.k_wr_en   = 1'b0;
    bus.k_wr_ch   = '0;
    bus.k_wr_idx  = '0;
    bus.k_wr_data = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{16'h0400, 16'h0200, 16'h0400, 16'h6400, 16'h3200};
    vecs[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
    vecs[2] = '{16'h0400, 16'h0000, 16'hFC00, 16'h9C00, 16'h0000};
    vecs[3] = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'h0400, 16'hFC00, 16'h0520, 16'h7FFF, 16'h8000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_last", 32'(bus.out_last), 32'd0);
    check("reset out_data", bus.out_data, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    load_w(16'h0400, 16'h0800, 1'b1);
    for (int idx = K * K; idx < 32; idx++) begin
      wr(0, idx, 16'h7FFF);
      wr(1, idx, 16'h7FFF);
    end
    wr_end();
    run_frame(1, 16'h0, 16'h0, 16'h0, 1, 2, 0, 1'b0);
    run_frame(1, 16'h0, 16'h0, 16'h0, 2, 1, 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      load_w(vecs[i].w0, vecs[i].w1, 1'b0);
      run_frame(0, vecs[i].pix, vecs[i].e0, vecs[i].e1, 1, i % 2, 0, 1'b0);
    end

    load_w(16'h0400, 16'h0800, 1'b1);
    run_frame(1, 16'h0, 16'h0, 16'h0, 1, 0, 101, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    #1;
    check("midreset out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset in_ready", 32'(bus.in_ready), 32'd1);
    run_frame(1, 16'h0, 16'h0, 16'h0, 1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_stream_engine.md
CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 SHALL have parameter BITWIDTH, default 16, signed fixed-point sample/weight width.
REQ-002 SHALL have parameter FRAC, default 10, fractional bits of samples and weights.
REQ-003 SHALL have parameters IMG_W, default 32, and IMG_H, default 32, frame width/height in pixels (padded input).
REQ-004 SHALL have parameter K, default 5, square kernel size; K <= IMG_W and K <= IMG_H.
REQ-005 SHALL have parameter CH, default 2, output channels computed in parallel.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 SHALL have ports: k_wr_en  in  1  weight write strobe; k_wr_ch  in  clog2(CH)  channel; k_wr_idx  in  clog2(K*K)  row-major tap; k_wr_data  in  BITWIDTH  signed weight.
REQ-008 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  BITWIDTH  signed pixel, raster order.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  CH*BITWIDTH  channel c at bits [c*BITWIDTH +: BITWIDTH]; out_last  out  1  final output of frame.
REQ-010 SHALL have port busy  out  1, high while a frame is partially received or an output is pending.

Function
REQ-011 SHALL accept a pixel when in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-012 SHALL track column/row counters, wrap column at IMG_W-1, row at IMG_H-1; after final pixel both return to 0 (next frame starts back-to-back).
REQ-013 SHALL hold K-1 line buffers of IMG_W entries plus a KxK window register shifted on each accepted pixel.
REQ-014 SHALL produce one output per accepted pixel with row >= K-1 and col >= K-1: (IMG_H-K+1)x(IMG_W-K+1) outputs per frame, raster order.
REQ-015 SHALL register output: out_valid rises the cycle after accepting the completing pixel; out_data/out_last stable while out_valid && !out_ready.
REQ-016 SHALL compute per channel sum of K*K full-precision products into 2*BITWIDTH+clog2(K*K) bits, arithmetic shift right FRAC, saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-017 SHALL assert out_last with the output at window origin (IMG_H-K, IMG_W-K).
REQ-018 SHALL implement FSM IDLE (counters zero, nothing pending) -> ACTIVE (first pixel accepted) -> IDLE when final output accepted and no new-frame pixel accepted; ACTIVE persists if next frame's first pixel is accepted same cycle.
REQ-019 SHALL write weights only when k_wr_en && !busy; writes while busy ignored; weights not cleared by frame end.
REQ-020 SHALL treat out-of-range k_wr_ch/k_wr_idx writes as no-ops.

Reset
REQ-021 SHALL on rst_n low: out_valid=0, out_last=0, out_data=0, busy=0, counters=0, FSM=IDLE; in_ready=1 next cycle.
REQ-022 SHALL discard a partial frame on reset mid-operation; line buffer and weight contents need not be cleared.

Configuration
REQ-023 SHALL, with CONV_RELU_EN defined, clamp each saturated channel result below 0 to 0; without it, output signed saturated result unchanged.

Structure
REQ-024 SHALL place fixed-point saturate function, FSM state typedef and default parameter constants in shared package conv_pkg.
REQ-025 SHALL instantiate CH copies of sub-module conv_window_mac (KxK window x KxK weights -> saturated BITWIDTH result, combinational).

Verification
REQ-026 Identity kernel (tap 12 = 0x0400, others 0), image p[r][c]=r*32+c -> out[i][j] = (i+2)*32+(j+2), 784 outputs, out_last on 784th.
REQ-027 All taps 0x0400, all pixels 0x0400 -> every output 0x6400 (25.0).
REQ-028 All taps/pixels 0x7FFF -> 0x7FFF; taps 0x8000, pixels 0x7FFF -> 0x8000 (0x0000 with CONV_RELU_EN).
REQ-029 out_ready low 10 cycles mid-frame -> in_ready low, out_data held, no output lost or duplicated.
REQ-030 rst_n low 1 cycle after pixel 100 -> out_valid=0, busy=0; following full frame matches REQ-026; weight write during busy ignored.
